seg7_scan_mux: RTL and testbench
================================

# seg7_scan_mux

Time-multiplexed seven-segment driver for the three-digit BCD counter. It consumes the counter's `units`/`tens`/`hundreds` nibbles and scans them onto a shared segment bus with one-hot digit anodes. Polarity is selectable for common-anode or common-cathode boards. Digits are snapshotted once per frame and anti-ghosting dead time is inserted between digits. It sits directly downstream of the counter in the top level and drives the board pins.

## Interface
- `REFRESH_DIV`, default 1000: clock cycles per digit slot; must be ≥ 2 and > `DEAD_CYCLES`.
- `DEAD_CYCLES`, default 16: cycles at the start of each slot with all anodes off; 0 disables dead time.
- `BLANK_LZ`, default 1: 1 = leading-zero blanking enabled.

Ports:
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: scan enable; 0 = display dark, scan frozen.
- `cathod` input 1: 0 = common anode (active-low seg/an/dp), 1 = common cathode (active-high).
- `units`, `tens`, `hundreds` input 4 each: BCD digits from the counter.
- `dp_en` input 3: decimal point request per digit, bit 0 = units.
- `seg` output 7: {g,f,e,d,c,b,a}, polarity per `cathod`.
- `an` output 3: digit enables, bit 0 = units, polarity per `cathod`.
- `dp` output 1: decimal point, polarity per `cathod`.
- `other_an` output 5: unused board digits, constantly at the off level.

## Operation
- Internal logic is active-high. Polarity is applied combinationally after the output registers: if `cathod`=0, all outputs are inverted. A `cathod` change therefore takes effect in the same cycle.
- Prescaler `div_cnt` counts 0..`REFRESH_DIV`-1 while `en`=1. At terminal count it wraps to 0 and the slot index `idx` advances 0→1→2→0 (units, tens, hundreds).
- Shadow registers hold the three digits. They load from the inputs on the first enabled cycle after reset, and on every cycle where `idx` wraps 2→0. Digits do not tear within a frame.
- Slot phases:
  - DEAD: `div_cnt` < `DEAD_CYCLES`. All anodes are off and `seg`/`dp` are off.
  - ACTIVE: the remainder of the slot. `an` is one-hot on `idx`, `seg` is the decode of `shadow[idx]`, and `dp` = `dp_en[idx]`.
- Decode: 0–9 use standard glyphs (0 = 0x3F, 1 = 0x06, …, 9 = 0x6F). Codes 10–15 show a dash (0x40).
- Leading-zero blanking (`BLANK_LZ`=1):
  - Hundreds is blanked if `shadow_h`=0.
  - Tens is blanked if `shadow_h`=0 and `shadow_t`=0.
  - Units is never blanked.
  - A blanked digit keeps its anode on, but `seg`=0 and `dp` still follows `dp_en`.
- `en`=0: `div_cnt`, `idx` and shadows hold, and the internal `an`/`seg`/`dp` registers go to 0. On `en` rising, the scan resumes from the held `div_cnt`/`idx`.
- `other_an` is internal 0 and is never driven on.

## Timing
- Reset values (internal): `div_cnt`=0, `idx`=0, shadows=0, `seg`=0, `an`=0, `dp`=0, and the first-load flag set. At the pins, all outputs sit at the off level: all 1s when `cathod`=0, all 0s when `cathod`=1.
- Outputs are registered with 1-cycle latency. The state (`div_cnt`, `idx`) at edge *k* determines `an`/`seg` after edge *k*+1.
- Frame period is 3·`REFRESH_DIV` cycles. The ACTIVE window per digit is `REFRESH_DIV`−`DEAD_CYCLES` cycles.
- Reset asserted mid-slot: all outputs go off immediately (asynchronous). After release, the scan restarts at units with `div_cnt`=0.
- Simultaneous shadow load and digit-input change: the value present at that clock edge is captured.

## Structure
- `seg7_pkg` contains:
  - the `digit_idx_t` typedef (2 bits);
  - constants `SEG_BLANK`=7'h00 and `SEG_DASH`=7'h40;
  - the glyph table constants.
- One combinational sub-module, `seg7_decoder` (4-bit BCD to 7-bit active-high segments). It is instantiated once, on the muxed shadow digit.
- Top-level integration: the counter's `units`/`tens`/`hundreds` wire straight into this block, and `cathod`/`en` come from board inputs.

## Test plan
All scenarios use `REFRESH_DIV`=4 and `DEAD_CYCLES`=1.
- **Reset and polarity.** Hold `rst`=1 with `cathod`=0. Require `seg`=7'h7F, `an`=3'b111, `dp`=1, `other_an`=5'h1F. Toggle `cathod`=1 in the same cycle and require all outputs to go to 0.
- **Scan order.** Digits 1,2,3 (h,t,u), `BLANK_LZ`=1, `cathod`=1. Require:
  - `an` sequence 000,001,001,001,000,010,… per slot;
  - `seg` = 0x4F while units is active, 0x5B for tens, 0x06 for hundreds;
  - frame period of 12 cycles.
- **Leading zeros.** Digits 0,0,7: hundreds and tens slots have their anode on with `seg`=0, and units shows 0x07. Digits 0,0,0: units shows 0x3F. With `BLANK_LZ`=0, 000 shows 0x3F on all three digits.
- **Snapshot.** Change `units` from 5 to 9 during the tens slot. The display keeps 5 until the next 2→0 wrap, then shows 0x6F.
- **Enable gating and invalid codes.** Drop `en` mid-ACTIVE: the next cycle shows everything off, and `idx` is held. Re-raise `en`: the scan resumes in the same slot. Drive `units`=4'hB: the units slot shows 0x40.
- **Mid-scan reset.** Assert `rst` during the hundreds slot. Outputs go off asynchronously. After release, the first ACTIVE slot is units, starting 2 cycles after release (1 DEAD cycle plus 1 cycle of register latency).

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scan driver.
//   digit_idx_t : scan slot index (units, tens, hundreds)
//   SEG_BLANK   : all segments off
//   SEG_DASH    : middle bar only, shown for non-BCD codes
//   GLYPH_0..9  : active-high {g,f,e,d,c,b,a} patterns for decimal digits
package seg7_pkg;

  typedef enum logic [1:0] {
    DIG_UNITS    = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2
  } digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational BCD to seven-segment decode.
//   bcd : 4-bit digit code; 0-9 decode to glyphs, 10-15 show a dash
//   seg : active-high segments {g,f,e,d,c,b,a}
import seg7_pkg::*;

module seg7_decoder (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = GLYPH_0;
      4'd1:    seg = GLYPH_1;
      4'd2:    seg = GLYPH_2;
      4'd3:    seg = GLYPH_3;
      4'd4:    seg = GLYPH_4;
      4'd5:    seg = GLYPH_5;
      4'd6:    seg = GLYPH_6;
      4'd7:    seg = GLYPH_7;
      4'd8:    seg = GLYPH_8;
      4'd9:    seg = GLYPH_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed three-digit seven-segment driver.
//   clk, rst       : system clock (rising edge), asynchronous active-high reset
//   en             : scan enable; low blanks the display and freezes the scan
//   cathod         : 1 = common cathode (active-high pins), 0 = common anode
//   units/tens/hundreds : BCD digits, snapshotted once per frame
//   dp_en          : per-digit decimal point request, bit 0 = units
//   seg, an, dp    : segment bus, one-hot digit enables, decimal point
//   other_an       : unused board digit enables, held at the off level
import seg7_pkg::*;

module seg7_scan_mux #(
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned DEAD_CYCLES = 16,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       cathod,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [2:0] dp_en,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       dp,
  output logic [4:0] other_an
);

  localparam int unsigned   DIV_W    = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] div_cnt, div_cnt_d;
  digit_idx_t       idx, idx_d;
  logic [3:0]       sh_u, sh_t, sh_h;
  logic             first_load;
  logic             load;

  logic [3:0]       cur_digit;
  logic [6:0]       dec_seg;
  logic             dead;
  logic             blank;
  logic [6:0]       seg_d, seg_q;
  logic [2:0]       an_d, an_q;
  logic             dp_d, dp_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      idx        <= DIG_UNITS;
      sh_u       <= '0;
      sh_t       <= '0;
      sh_h       <= '0;
      first_load <= 1'b1;
    end else begin
      div_cnt <= div_cnt_d;
      idx     <= idx_d;
      if (load) begin
        sh_u <= units;
        sh_t <= tens;
        sh_h <= hundreds;
      end
      if (en) begin
        first_load <= 1'b0;
      end
    end
  end

  // Next-state: prescaler, slot advance and shadow-load strobe
  always_comb begin
    div_cnt_d = div_cnt;
    idx_d     = idx;
    load      = 1'b0;
    if (en) begin
      load = first_load;
      if (div_cnt == DIV_LAST) begin
        div_cnt_d = '0;
        case (idx)
          DIG_UNITS: idx_d = DIG_TENS;
          DIG_TENS:  idx_d = DIG_HUNDREDS;
          default: begin
            idx_d = DIG_UNITS;
            load  = 1'b1;
          end
        endcase
      end else begin
        div_cnt_d = div_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    case (idx)
      DIG_UNITS: cur_digit = sh_u;
      DIG_TENS:  cur_digit = sh_t;
      default:   cur_digit = sh_h;
    endcase
  end

  seg7_decoder u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Output decode from the current state; registered below
  always_comb begin
    dead  = (32'(div_cnt) < DEAD_CYCLES);
    blank = 1'b0;
    if (BLANK_LZ) begin
      case (idx)
        DIG_TENS:     blank = (sh_h == 4'd0) && (sh_t == 4'd0);
        DIG_HUNDREDS: blank = (sh_h == 4'd0);
        default:      blank = 1'b0;
      endcase
    end

    seg_d = SEG_BLANK;
    an_d  = '0;
    dp_d  = 1'b0;
    if (en && !dead) begin
      case (idx)
        DIG_UNITS: begin
          an_d = 3'b001;
          dp_d = dp_en[0];
        end
        DIG_TENS: begin
          an_d = 3'b010;
          dp_d = dp_en[1];
        end
        default: begin
          an_d = 3'b100;
          dp_d = dp_en[2];
        end
      endcase
      seg_d = blank ? SEG_BLANK : dec_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= '0;
      an_q  <= '0;
      dp_q  <= 1'b0;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  // Polarity is applied after the registers so a cathod change is immediate
  always_comb begin
    seg      = cathod ? seg_q : ~seg_q;
    an       = cathod ? an_q  : ~an_q;
    dp       = cathod ? dp_q  : ~dp_q;
    other_an = cathod ? '0    : '1;
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: self-checking bench for seg7_scan_mux with a small
// refresh divider. Two instances share stimulus: one with leading-zero
// blanking, one without. A frame-level reference model runs alongside.
module tb_seg7_scan_mux;

  localparam int unsigned RD = 4;
  localparam int unsigned DC = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       cathod = 1'b0;
  logic [3:0] units = 4'd0, tens = 4'd0, hundreds = 4'd0;
  logic [2:0] dp_en = 3'd0;

  logic [6:0] seg_b, seg_n;
  logic [2:0] an_b, an_n;
  logic       dp_b, dp_n;
  logic [4:0] oa_b, oa_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_scan_mux #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .cathod(cathod),
    .units(units), .tens(tens), .hundreds(hundreds), .dp_en(dp_en),
    .seg(seg_b), .an(an_b), .dp(dp_b), .other_an(oa_b)
  );

  seg7_scan_mux #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC), .BLANK_LZ(1'b0)) dut_n (
    .clk(clk), .rst(rst), .en(en), .cathod(cathod),
    .units(units), .tens(tens), .hundreds(hundreds), .dp_en(dp_en),
    .seg(seg_n), .an(an_n), .dp(dp_n), .other_an(oa_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  int unsigned mt;          // enabled cycles since reset
  int unsigned mslot;
  logic [3:0]  snap [3];
  logic [6:0]  mseg_b, mseg_n;
  logic [2:0]  man;
  logic        mdp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mt = 0;
      snap = '{default: 4'd0};
      mseg_b = '0; mseg_n = '0; man = '0; mdp = 1'b0;
    end else if (!en) begin
      mseg_b = '0; mseg_n = '0; man = '0; mdp = 1'b0;
    end else begin
      mslot = (mt / RD) % 3;
      if ((mt % RD) < DC) begin
        mseg_b = '0; mseg_n = '0; man = '0; mdp = 1'b0;
      end else begin
        man    = 3'(1 << mslot);
        mdp    = dp_en[mslot];
        mseg_n = glyph[snap[mslot]];
        mseg_b = mseg_n;
        if (mslot == 2 && snap[2] == 4'd0) mseg_b = '0;
        if (mslot == 1 && snap[2] == 4'd0 && snap[1] == 4'd0) mseg_b = '0;
      end
      if (mt == 0 || (mt % (3 * RD)) == (3 * RD - 1)) begin
        snap[0] = units; snap[1] = tens; snap[2] = hundreds;
      end
      mt++;
    end
  end

  logic [6:0] e_seg_b, e_seg_n;
  logic [2:0] e_an;
  logic       e_dp;
  logic [4:0] e_oa;

  always begin
    @(negedge clk);
    #1;
    e_seg_b = cathod ? mseg_b : ~mseg_b;
    e_seg_n = cathod ? mseg_n : ~mseg_n;
    e_an    = cathod ? man : ~man;
    e_dp    = cathod ? mdp : ~mdp;
    e_oa    = cathod ? 5'h00 : 5'h1F;
    check("model_seg_b", 32'(seg_b), 32'(e_seg_b));
    check("model_an_b",  32'(an_b),  32'(e_an));
    check("model_dp_b",  32'(dp_b),  32'(e_dp));
    check("model_oa_b",  32'(oa_b),  32'(e_oa));
    check("model_seg_n", 32'(seg_n), 32'(e_seg_n));
    check("model_an_n",  32'(an_n),  32'(e_an));
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] h, t, u;
    logic [6:0] su_b, st_b, sh_b;
    logic [6:0] su_n, st_n, sh_n;
  } vec_t;

  vec_t vecs [6];
  logic [2:0] an_seq [13] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010,
                              3'b010, 3'b000, 3'b100, 3'b100, 3'b100, 3'b000};

  initial begin
    vecs[0] = '{4'd1, 4'd2, 4'd3,  7'h4F, 7'h5B, 7'h06,  7'h4F, 7'h5B, 7'h06};
    vecs[1] = '{4'd0, 4'd0, 4'd7,  7'h07, 7'h00, 7'h00,  7'h07, 7'h3F, 7'h3F};
    vecs[2] = '{4'd0, 4'd0, 4'd0,  7'h3F, 7'h00, 7'h00,  7'h3F, 7'h3F, 7'h3F};
    vecs[3] = '{4'd0, 4'd5, 4'd0,  7'h3F, 7'h6D, 7'h00,  7'h3F, 7'h6D, 7'h3F};
    vecs[4] = '{4'd7, 4'd0, 4'hB,  7'h40, 7'h3F, 7'h07,  7'h40, 7'h3F, 7'h07};
    vecs[5] = '{4'hF, 4'hA, 4'd8,  7'h7F, 7'h40, 7'h40,  7'h7F, 7'h40, 7'h40};

    // Reset and polarity
    #1;
    check("rst_seg_ca", 32'(seg_b), 32'h7F);
    check("rst_an_ca",  32'(an_b),  32'h7);
    check("rst_dp_ca",  32'(dp_b),  32'h1);
    check("rst_oa_ca",  32'(oa_b),  32'h1F);
    cathod = 1'b1;
    #1;
    check("rst_seg_cc", 32'(seg_b), 32'h00);
    check("rst_an_cc",  32'(an_b),  32'h0);
    check("rst_dp_cc",  32'(dp_b),  32'h0);
    check("rst_oa_cc",  32'(oa_b),  32'h00);

    // Per-digit decode, blanking and invalid codes
    for (int i = 0; i < 6; i++) begin
      hundreds = vecs[i].h; tens = vecs[i].t; units = vecs[i].u;
      do_reset();
      tick(3);
      check("tbl_an_u",  32'(an_b),  32'h1);
      check("tbl_seg_u_b", 32'(seg_b), 32'(vecs[i].su_b));
      check("tbl_seg_u_n", 32'(seg_n), 32'(vecs[i].su_n));
      tick(4);
      check("tbl_an_t",  32'(an_b),  32'h2);
      check("tbl_seg_t_b", 32'(seg_b), 32'(vecs[i].st_b));
      check("tbl_seg_t_n", 32'(seg_n), 32'(vecs[i].st_n));
      tick(4);
      check("tbl_an_h",  32'(an_b),  32'h4);
      check("tbl_seg_h_b", 32'(seg_b), 32'(vecs[i].sh_b));
      check("tbl_seg_h_n", 32'(seg_n), 32'(vecs[i].sh_n));
    end

    // Scan order, dead time and frame period
    hundreds = 4'd1; tens = 4'd2; units = 4'd3; dp_en = 3'b010;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      tick(1);
      check("scan_an", 32'(an_b), 32'(an_seq[k]));
      if (k == 1) check("scan_dp_u", 32'(dp_b), 32'h0);
      if (k == 5) check("scan_dp_t", 32'(dp_b), 32'h1);
    end
    tick(1);
    check("frame_an",  32'(an_b),  32'h1);
    check("frame_seg", 32'(seg_b), 32'h4F);

    // Snapshot: a units change mid-frame appears only after the wrap
    units = 4'd5; dp_en = 3'b000;
    do_reset();
    tick(2);
    check("snap_old", 32'(seg_b), 32'h6D);
    tick(4);
    units = 4'd9;
    tick(8);
    check("snap_an",  32'(an_b),  32'h1);
    check("snap_new", 32'(seg_b), 32'h6F);

    // Enable gating resumes in the same slot
    units = 4'd3; dp_en = 3'b001;
    do_reset();
    tick(3);
    check("en_pre_an", 32'(an_b), 32'h1);
    en = 1'b0;
    tick(1);
    check("en_off_an",  32'(an_b),  32'h0);
    check("en_off_seg", 32'(seg_b), 32'h00);
    check("en_off_dp",  32'(dp_b),  32'h0);
    tick(2);
    check("en_hold_an", 32'(an_b), 32'h0);
    en = 1'b1;
    tick(1);
    check("en_res_an",  32'(an_b),  32'h1);
    check("en_res_seg", 32'(seg_b), 32'h4F);
    check("en_res_dp",  32'(dp_b),  32'h1);
    tick(1);
    check("en_dead_an", 32'(an_b), 32'h0);
    tick(1);
    check("en_tens_an", 32'(an_b), 32'h2);

    // Mid-scan asynchronous reset, common-anode pins
    cathod = 1'b0; dp_en = 3'b100;
    do_reset();
    tick(10);
    check("mrst_pre_an", 32'(an_b), 32'h3);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_an",  32'(an_b),  32'h7);
    check("mrst_seg", 32'(seg_b), 32'h7F);
    check("mrst_dp",  32'(dp_b),  32'h1);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    check("mrst_dead_an", 32'(an_b), 32'h7);
    tick(1);
    check("mrst_u_an",  32'(an_b),  32'h6);
    check("mrst_u_seg", 32'(seg_b), 32'h30);

    // Randomized run against the model
    cathod = 1'b1;
    do_reset();
    repeat (3000) begin
      @(negedge clk);
      rst = 1'b0;
      if ($urandom_range(7) == 0) begin
        units    = 4'($urandom_range(15));
        tens     = 4'($urandom_range(15));
        hundreds = 4'($urandom_range(15));
        if ($urandom_range(1) == 0) hundreds = 4'd0;
        if ($urandom_range(2) == 0) tens = 4'd0;
      end
      dp_en = 3'($urandom_range(7));
      en    = ($urandom_range(7) != 0);
      if ($urandom_range(15) == 0) cathod = ~cathod;
      if ($urandom_range(199) == 0) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
